// File: rtl/window_if.sv
// Pixel stream in, parallel KSIZE x KSIZE window out. The master drives pixels;
// the slave (the window generator) returns windows and the frame marker.
interface window_if #(
  parameter int KSIZE      = 5,
  parameter int PIXELWIDTH = 8
);
  logic [PIXELWIDTH-1:0]             pixel_in;
  logic                              pixel_valid;
  logic [KSIZE*KSIZE*PIXELWIDTH-1:0] window;
  logic                              window_valid;
  logic                              frame_done;

  modport master (
    output pixel_in, pixel_valid,
    input  window, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid,
    output window, window_valid, frame_done
  );
endinterface

// File: rtl/window_generator.sv
// Sliding-window stage: buffers KSIZE-1 image rows and emits every complete
// KSIZE x KSIZE neighbourhood one cycle after its bottom-right pixel arrives.
module window_generator #(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int KSIZE      = 5,
  parameter int PIXELWIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  window_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef logic [PIXELWIDTH-1:0] pixel_t;
  typedef logic [CW-1:0]         col_t;
  typedef logic [RW-1:0]         row_t;

  localparam col_t COL_FIRST = col_t'(KSIZE - 1);
  localparam col_t COL_LAST  = col_t'(WIDTH - 1);
  localparam row_t ROW_FIRST = row_t'(KSIZE - 1);
  localparam row_t ROW_LAST  = row_t'(HEIGHT - 1);

  col_t   col;
  row_t   row;
  pixel_t line_buf [KSIZE-1][WIDTH];
  pixel_t win      [KSIZE][KSIZE];
  pixel_t new_col  [KSIZE];
  logic   window_valid;
  logic   frame_done;
  logic   accept;

  assign accept = bus.pixel_valid;

  // Column entering the window: oldest buffered row on top, live pixel at the bottom.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int r = 0; r < KSIZE; r++) new_col[r] = '0;
    for (int r = 0; r < KSIZE - 1; r++) new_col[r] = line_buf[KSIZE-2-r][col];
    new_col[KSIZE-1] = bus.pixel_in;
  end

  // NOTE: the line buffers are plain RAM with no reset; every entry is rewritten
  // a full row before it can reach a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col] <= bus.pixel_in;
      for (int i = 1; i < KSIZE - 1; i++) line_buf[i][col] <= line_buf[i-1][col];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every right-hand side sees pre-edge state.
      window_valid <= accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
      frame_done   <= accept && (row == ROW_LAST) && (col == COL_LAST);
      if (accept) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) win[r][c] <= win[r][c+1];
          win[r][KSIZE-1] <= new_col[r];
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.window = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        bus.window[(r*KSIZE+c)*PIXELWIDTH +: PIXELWIDTH] = win[r][c];
  end

  assign bus.window_valid = window_valid;
  assign bus.frame_done   = frame_done;
endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench: KSIZE=5 and KSIZE=3 instances share one pixel stream and
// are compared against an image-array reference model.
module tb_window_generator;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int VW = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_if #(.KSIZE(5), .PIXELWIDTH(8)) bus5 ();
  window_if #(.KSIZE(3), .PIXELWIDTH(8)) bus3 ();

  window_generator #(.WIDTH(W), .HEIGHT(H), .KSIZE(5), .PIXELWIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave));
  window_generator #(.WIDTH(W), .HEIGHT(H), .KSIZE(3), .PIXELWIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model: the current frame as a plain image plus the raster position.
  logic [7:0]    img [H][W];
  int            m_row, m_col, last_idx;
  logic          known5, known3;
  logic [VW-1:0] exp_win5, exp_win3;

  // Per-run statistics gathered from what the DUTs present.
  int            wins5, wins3, dones, first_idx5, first_idx3;
  int            row_wins5 [H];
  logic          done_with_valid;
  logic [VW-1:0] first_w5, first_w3, last_w5, row5_w;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] expect_win(input int k, input int row, input int col);
    logic [VW-1:0] w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        w[(r*k+c)*8 +: 8] = img[row-k+1+r][col-k+1+c];
    return w;
  endfunction

  function automatic logic [7:0] elem(input logic [VW-1:0] w, input int k, input int r, input int c);
    return w[(r*k+c)*8 +: 8];
  endfunction

  task automatic clear_stats();
    wins5 = 0; wins3 = 0; dones = 0; first_idx5 = -1; first_idx3 = -1;
    done_with_valid = 1'b1;
    for (int i = 0; i < H; i++) row_wins5[i] = 0;
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    known5 = 1'b1; known3 = 1'b1; exp_win5 = '0; exp_win3 = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_window5"}, bus5.window, '0);
    check({tag, "_window3"}, {{(VW-72){1'b0}}, bus3.window}, '0);
    check({tag, "_valid5"}, bus5.window_valid, 0);
    check({tag, "_valid3"}, bus3.window_valid, 0);
    check({tag, "_done5"}, bus5.frame_done, 0);
    check({tag, "_done3"}, bus3.frame_done, 0);
  endtask

  task automatic step(input logic v, input logic [7:0] p);
    logic ev5, ev3, edone;
    bus5.pixel_in = p; bus5.pixel_valid = v;
    bus3.pixel_in = p; bus3.pixel_valid = v;
    @(posedge clk); #1;
    ev5 = 1'b0; ev3 = 1'b0; edone = 1'b0;
    if (v) begin
      last_idx = m_row * W + m_col;
      img[m_row][m_col] = p;
      ev5   = (m_row >= 4) && (m_col >= 4);
      ev3   = (m_row >= 2) && (m_col >= 2);
      edone = (m_row == H-1) && (m_col == W-1);
      if (ev5) exp_win5 = expect_win(5, m_row, m_col);
      if (ev3) exp_win3 = expect_win(3, m_row, m_col);
      known5 = ev5; known3 = ev3;
      m_col = (m_col + 1) % W;
      if (m_col == 0) m_row = (m_row + 1) % H;
    end
    check("valid5", bus5.window_valid, ev5);
    check("valid3", bus3.window_valid, ev3);
    check("done5", bus5.frame_done, edone);
    check("done3", bus3.frame_done, edone);
    if (known5) check("window5", bus5.window, exp_win5);
    if (known3) check("window3", {{(VW-72){1'b0}}, bus3.window}, exp_win3);
    if (bus5.window_valid) begin
      wins5++;
      if (first_idx5 < 0) begin first_idx5 = last_idx; first_w5 = bus5.window; end
      row_wins5[last_idx / W]++;
      last_w5 = bus5.window;
      if (v && last_idx == 5*W + 4) row5_w = bus5.window;
    end
    if (bus3.window_valid) begin
      wins3++;
      if (first_idx3 < 0) begin first_idx3 = last_idx; first_w3 = {{(VW-72){1'b0}}, bus3.window}; end
    end
    if (bus5.frame_done) begin
      dones++;
      if (!bus5.window_valid) done_with_valid = 1'b0;
    end
  endtask

  // mode: 0 ramp, 1 inverted ramp, 2 random; vmode: 0 continuous, 1 toggling, 2 random gaps
  task automatic send_pixels(input int n, input int mode, input int vmode);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = (mode == 0) ? 8'(i) : (mode == 1) ? ~8'(i) : 8'($urandom);
      if (vmode == 2) while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
      step(1'b1, p);
      if (vmode == 1) step(1'b0, 8'($urandom));
    end
  endtask

  task automatic run_checks(input int nframes, input bit ramp_spot);
    check("win_count5", wins5, 784 * nframes);
    check("win_count3", wins3, 900 * nframes);
    check("frame_done_count", dones, nframes);
    check("done_with_last_window", done_with_valid, 1);
    for (int r = 0; r < H; r++)
      check($sformatf("row_wins5_%0d", r), row_wins5[r], (r >= 4) ? 28 * nframes : 0);
    if (ramp_spot) begin
      check("first_idx5", first_idx5, 132);
      check("first5_00", elem(first_w5, 5, 0, 0), 8'h00);
      check("first5_22", elem(first_w5, 5, 2, 2), 8'h42);
      check("first5_44", elem(first_w5, 5, 4, 4), 8'h84);
      check("row5_first_00", elem(row5_w, 5, 0, 0), 8'h20);
      check("first_idx3", first_idx3, 66);
      check("first3_00", elem(first_w3, 3, 0, 0), 8'h00);
      check("first3_22", elem(first_w3, 3, 2, 2), 8'h42);
    end
  endtask

  initial begin
    bus5.pixel_in = '0; bus5.pixel_valid = 1'b0;
    bus3.pixel_in = '0; bus3.pixel_valid = 1'b0;
    model_reset();
    last_idx = 0;
    #1 check_idle_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset_hold");
    @(negedge clk) rst = 1'b1;
    step(1'b0, 8'h5A);

    // Continuous ramp frame.
    clear_stats();
    send_pixels(W*H, 0, 0);
    run_checks(1, 1);
    check("ramp_last5_44", elem(last_w5, 5, 4, 4), 8'hFF);

    // Same ramp with valid toggling every cycle.
    clear_stats();
    send_pixels(W*H, 0, 1);
    run_checks(1, 1);

    // Ramp followed immediately by an inverted ramp.
    clear_stats();
    send_pixels(W*H, 0, 0);
    send_pixels(W*H, 1, 0);
    run_checks(2, 0);
    check("inv_last5_44", elem(last_w5, 5, 4, 4), 8'h00);

    // Reset mid-frame, then a clean ramp.
    send_pixels(500, 2, 0);
    #2 rst = 1'b0;
    #1 check_idle_outputs("reset_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset_mid");
    @(negedge clk) rst = 1'b1;
    clear_stats();
    send_pixels(W*H, 0, 0);
    run_checks(1, 1);

    // Random pixels with random gaps.
    clear_stats();
    send_pixels(W*H, 2, 2);
    run_checks(1, 0);

    repeat (3) step(1'b0, 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/window_generator.md
# window_generator

Streaming sliding-window stage between the image reader and the first convolution layer. It accepts one raster-order pixel per valid cycle and buffers the most recent KSIZE-1 image rows in on-chip line buffers. For every pixel that completes a full KSIZE×KSIZE neighbourhood, it emits that window in parallel. It tracks row and column position, suppresses windows that straddle the left edge or the first rows, and flags end of frame.

## Interface
- WIDTH, 32, pixels per image row
- HEIGHT, 32, rows per image
- KSIZE, 5, window edge length (conv kernel size); 2 ≤ KSIZE ≤ min(WIDTH, HEIGHT)
- PIXELWIDTH, 8, bits per pixel

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- pixel_in  input  PIXELWIDTH  next raster-order pixel
- pixel_valid  input  1  pixel_in accepted this cycle when high; tie high for a free-running reader
- window  output  KSIZE*KSIZE*PIXELWIDTH  element (r,c) at bits [(r*KSIZE+c)*PIXELWIDTH +: PIXELWIDTH]; r=0 is the top (oldest) row, c=0 is the leftmost column
- window_valid  output  1  window holds a complete, in-image neighbourhood
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Counters: col in 0..WIDTH-1 and row in 0..HEIGHT-1, both reset to 0. They advance only on accepted pixels.
  - col wraps WIDTH-1→0 and increments row.
  - row wraps HEIGHT-1→0 at (HEIGHT-1, WIDTH-1). No idle cycle is needed between frames.
- Line buffers: KSIZE-1 row memories of WIDTH entries, addressed by col.
  - On accept, column col of the buffers shifts up one row.
  - Buffer 0 receives pixel_in. Read and write of the same address in one cycle use the old data.
- Window register: on accept, all columns shift left by one (c ← c+1).
  - New column c=KSIZE-1 = {buffer rows (oldest→newest) at col, pixel_in}, with row KSIZE-1 = pixel_in.
- Validity: after accepting pixel (row, col), window_valid is high on the next cycle iff row ≥ KSIZE-1 and col ≥ KSIZE-1.
  - Window (r,c) then equals image pixel (row-KSIZE+1+r, col-KSIZE+1+c).
- Stale columns left in the window register after a column wrap are never flagged valid.
- Windows per frame: (WIDTH-KSIZE+1)×(HEIGHT-KSIZE+1), which is 784 for the defaults.
- No backpressure; the consumer must take every valid window.

## Timing
- Latency: 1 cycle from the accepting edge to window/window_valid.
- window_valid and frame_done are high for exactly one cycle per qualifying accepted pixel, and low on cycles after pixel_valid=0.
- While pixel_valid=0, window holds its value, and counters and buffers are frozen.
- frame_done is high the cycle after accepting (HEIGHT-1, WIDTH-1), coincident with the last window_valid.
- Reset values: window=0, window_valid=0, frame_done=0, col=0, row=0. Line buffer contents are not reset and are don't-care; they are always overwritten before contributing to a valid window.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). The next accepted pixel is treated as (0,0).
- Frame boundary with continuous valid: pixel (0,0) of the next frame may be accepted the cycle after (HEIGHT-1, WIDTH-1). Rows of the previous frame are never flagged in a valid window of the new frame.

## Test plan
- Ramp frame, pixel = (row*32+col) mod 256, pixel_valid constant 1 → first window_valid one cycle after pixel index 132. That window has (0,0)=0x00, (2,2)=0x42, (4,4)=0x84. The bench counts exactly 784 valid windows, and frame_done pulses once, coincident with the last window, whose (4,4)=0xFF.
- Same ramp with pixel_valid toggling 1,0,1,0 → identical window sequence, window_valid never high on two consecutive cycles, and window unchanged across gap cycles.
- Row-edge check on the ramp → in every row ≥4, no window_valid for cols 0–3 and exactly 28 valid windows. The first window of row 5 has (0,0) = pixel (1,0) = 0x20.
- Two back-to-back frames (second frame = bitwise-inverted ramp) with no gap → frame_done pulses twice. The second frame's windows match the inverted reference with no first-frame pixels.
- Reset pulse (rst low 2 cycles) after 500 pixels, then a full ramp → all outputs read 0 during reset, and the post-reset window sequence is identical to scenario 1.
- Parameter variant KSIZE=3 → 900 windows. The first valid window follows pixel index 66 with (0,0)=0x00 and (2,2)=0x42.
